// File: rtl/multicycle_control.sv
// multicycle_control: sequenced FETCH/DECODE/EXEC/MEM/WB controller for the multi-cycle LEGv8 datapath
module multicycle_control #(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 4,
  parameter int SIGNOP_W = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                imem_req,
  output logic                reg2loc,
  output logic                alusrc,
  output logic                mem2reg,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [SIGNOP_W-1:0] signop,
  output logic [2:0]          state,
  output logic                fault
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;
  typedef enum logic [3:0] {
    C_ILL, C_MOVZ, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_LDUR, C_STUR, C_CBZ, C_B
  } cls_t;
  state_t state_q, state_d;
  cls_t cls_q, cls_d, dec_cls, cls;
  logic [SIGNOP_W-1:0] sop_q, sop_d, dec_sop, sop;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout;
  // Opcode class decode in priority order; only consumed while in DECODE
  always_comb begin
    dec_cls = C_ILL;
    dec_sop = '0;
    casez (opcode)
      11'b110100101??: begin dec_cls = C_MOVZ; dec_sop = opcode[2:0]; end
      11'b?0001010???: dec_cls = C_AND;
      11'b?0101010???: dec_cls = C_ORR;
      11'b?0?01011???: dec_cls = C_ADD;
      11'b?1?01011???: dec_cls = C_SUB;
      11'b?0?10001???: begin dec_cls = C_ADDI; dec_sop = 3'b011; end
      11'b?1?10001???: begin dec_cls = C_SUBI; dec_sop = 3'b011; end
      11'b??111000010: begin dec_cls = C_LDUR; dec_sop = 3'b010; end
      11'b??111000000: begin dec_cls = C_STUR; dec_sop = 3'b010; end
      11'b?011010????: begin dec_cls = C_CBZ; dec_sop = 3'b001; end
      11'b?00101?????: dec_cls = C_B;
      default: ;
    endcase
  end
  // In DECODE the class register is not loaded yet, so look straight at the decoder
  assign cls = (state_q == S_DECODE) ? dec_cls : cls_q;
  assign sop = (state_q == S_DECODE) ? dec_sop : sop_q;
  assign cls_d = (state_q == S_DECODE) ? dec_cls : cls_q;
  assign sop_d = (state_q == S_DECODE) ? dec_sop : sop_q;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT));
  assign state = state_q;
  // Next-state and datapath controls; every output defaults to 0
  always_comb begin
    state_d  = state_q;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    ir_write = 1'b0;
    imem_req = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    aluop    = '0;
    signop   = '0;
    fault    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = mem_ready;
        state_d  = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        pc_write = (cls == C_ILL);
        state_d  = (cls == C_ILL) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        aluop = (cls == C_AND) ? 4'b0000 :
                (cls == C_ORR) ? 4'b0001 :
                (cls == C_SUB || cls == C_SUBI) ? 4'b0110 :
                (cls == C_MOVZ || cls == C_CBZ || cls == C_B) ? 4'b0111 : 4'b0010;
        alusrc   = (cls == C_ADDI || cls == C_SUBI || cls == C_MOVZ || cls == C_LDUR || cls == C_STUR);
        reg2loc  = (cls == C_STUR || cls == C_CBZ);
        signop   = sop;
        pc_write = (cls == C_CBZ || cls == C_B);
        pc_src   = (cls == C_B) || (cls == C_CBZ && zero);
        state_d  = (cls == C_CBZ || cls == C_B) ? S_FETCH :
                   (cls == C_LDUR || cls == C_STUR) ? S_MEM : S_WB;
      end
      S_MEM: begin
        memread  = (cls == C_LDUR);
        memwrite = (cls == C_STUR);
        pc_write = mem_ready && (cls == C_STUR);
        state_d  = mem_ready ? ((cls == C_LDUR) ? S_WB : S_FETCH) : timeout ? S_FAULT : S_MEM;
      end
      S_WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls == C_LDUR);
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end
  // Wait counter: cleared on any state change, counts stalled memory cycles
  assign cnt_d = (state_d != state_q) ? '0 :
                 ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) ? cnt_q + 1'b1 : cnt_q;
  // State, class and wait-counter registers
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      sop_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      sop_q   <= sop_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
